// File: rtl/text_banner_gen_pkg.sv
// Shared constants for the text banner overlay: screen geometry, glyph size
// and the 3-bit glyph code map used by the font ROM.
package text_banner_gen_pkg;

    localparam int MAX_X   = 640;
    localparam int MAX_Y   = 480;
    localparam int GLYPH_W = 8;

    typedef enum logic [2:0] {
        CODE_BLANK = 3'd0,
        CODE_I     = 3'd1,
        CODE_K     = 3'd2,
        CODE_R     = 3'd3,
        CODE_A     = 3'd4,
        CODE_S     = 3'd5,
        CODE_M     = 3'd6,
        CODE_C     = 3'd7
    } glyph_code_e;

endpackage

// File: rtl/text_banner_gen_font_rom.sv
// Combinational 8x8 glyph table. Each glyph is packed row 0 first (MSB byte),
// and bit 7 of a row is its leftmost pixel.
module font_rom_8x8
    import text_banner_gen_pkg::*;
(
    input  logic [2:0] code,
    input  logic [2:0] row,
    output logic [7:0] data
);

    logic [63:0] glyph;

    always_comb begin
        glyph = '0;
        case (glyph_code_e'(code))
            CODE_BLANK: glyph = 64'h0000000000000000;
            CODE_I:     glyph = 64'h3C1818181818183C;
            CODE_K:     glyph = 64'hC6CCD8F0D8CCC600;
            CODE_R:     glyph = 64'hFCC6C6FCD8CCC600;
            CODE_A:     glyph = 64'h386CC6C6FEC6C600;
            CODE_S:     glyph = 64'h7CC6C07C06C67C00;
            CODE_M:     glyph = 64'hC6EEFED6C6C6C600;
            CODE_C:     glyph = 64'h7CC6C0C0C0C67C00;
            default:    glyph = '0;
        endcase
    end

    // Row 0 sits in the top byte, so the byte offset is (7 - row) * 8.
    assign data = glyph[{~row, 3'b000} +: 8];

endmodule

// File: rtl/text_banner_gen.sv
// Text banner overlay: renders NCHAR scaled 8x8 glyphs at a scrolling origin,
// with frame-synchronous colour, blink and scroll state and a 2-clk pixel pipe.
module text_banner_gen
    import text_banner_gen_pkg::*;
#(
    parameter int X0           = 296,
    parameter int Y0           = 240,
    parameter int NCHAR        = 3,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic [3*NCHAR-1:0] char_codes,
    input  logic               switchR,
    input  logic               switchG,
    input  logic               switchB,
    input  logic               blink_en,
    input  logic               scroll_en,
    output logic [2:0]         graph_rgb
);

    localparam int          WIN_W       = (NCHAR * GLYPH_W) << SCALE_LOG2;
    localparam int          WIN_H       = GLYPH_W << SCALE_LOG2;
    localparam logic [10:0] X_LIMIT     = 11'(MAX_X);
    localparam logic [10:0] X0_W        = 11'(X0);
    localparam logic [10:0] Y_TOP       = 11'(Y0);
    localparam logic [10:0] Y_END       = 11'(Y0 + WIN_H);
    localparam logic [9:0]  Y0_W        = 10'(Y0);
    localparam logic [7:0]  BLINK_LAST  = 8'(BLINK_FRAMES - 1);
    localparam logic [9:0]  OFFSET_LAST = 10'(MAX_X - 1);

    // Frame tick: first clk of the (0, 480) sample, once per frame.
    logic tick_cond;
    logic tick_cond_q;
    logic frame_tick;

    assign tick_cond  = (pix_x == 10'(0)) && (pix_y == 10'(MAX_Y));
    assign frame_tick = tick_cond & ~tick_cond_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cond_q <= 1'b0;
        end else begin
            tick_cond_q <= tick_cond;
        end
    end

    // Colour only changes at frame boundaries so a frame is never two-tone.
    logic [2:0] colour_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colour_q <= 3'b111;
        end else if (frame_tick) begin
            colour_q <= {switchR, switchG, switchB};
        end
    end

    logic [7:0] blink_cnt_q;
    logic       blink_phase_q;
    logic       phase_eff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 8'd1;
            end
        end
    end

    // Clearing blink_en must show text on the very next pixel, not next clk.
    assign phase_eff = blink_phase_q | ~blink_en;

    logic [9:0] offset_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offset_q <= '0;
        end else if (frame_tick && scroll_en) begin
            offset_q <= (offset_q == OFFSET_LAST) ? 10'd0 : offset_q + 10'd1;
        end
    end

    // Origin wraps modulo the screen width; the window itself is clipped.
    logic [10:0] org_sum;
    logic [9:0]  x_org;
    logic [10:0] x_end;
    logic        x_in;
    logic        y_in;

    assign org_sum = X0_W + {1'b0, offset_q};
    assign x_org   = (org_sum >= X_LIMIT) ? 10'(org_sum - X_LIMIT) : org_sum[9:0];
    assign x_end   = {1'b0, x_org} + 11'(WIN_W);
    assign x_in    = ({1'b0, pix_x} >= {1'b0, x_org}) && ({1'b0, pix_x} < x_end) &&
                     ({1'b0, pix_x} < X_LIMIT);
    assign y_in    = ({1'b0, pix_y} >= Y_TOP) && ({1'b0, pix_y} < Y_END);

    logic [9:0] dx;
    logic [9:0] dy;
    logic [9:0] dx_sh;
    logic [2:0] cur_row;
    logic [2:0] cur_code;

    assign dx      = pix_x - x_org;
    assign dy      = pix_y - Y0_W;
    assign dx_sh   = dx >> SCALE_LOG2;
    assign cur_row = 3'(dy >> SCALE_LOG2);

    always_comb begin
        cur_code = '0;
        for (int i = 0; i < NCHAR; i++) begin
            if (dx_sh[9:3] == 7'(i)) begin
                cur_code = char_codes[3*i +: 3];
            end
        end
    end

    logic       hit_d;
    logic       von_d;
    logic [2:0] code_d;
    logic [2:0] row_d;
    logic [2:0] col_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_d  <= 1'b0;
            von_d  <= 1'b0;
            code_d <= '0;
            row_d  <= '0;
            col_d  <= '0;
        end else begin
            hit_d  <= x_in & y_in;
            von_d  <= video_on;
            code_d <= cur_code;
            row_d  <= cur_row;
            col_d  <= dx_sh[2:0];
        end
    end

    logic [7:0] glyph_row;
    logic       glyph_bit;

    font_rom_8x8 u_font (
        .code (code_d),
        .row  (row_d),
        .data (glyph_row)
    );

    assign glyph_bit = glyph_row[~col_d];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            graph_rgb <= 3'b000;
        end else if (von_d && hit_d && glyph_bit && phase_eff) begin
            graph_rgb <= colour_q;
        end else begin
            graph_rgb <= 3'b000;
        end
    end

endmodule

// File: tb/tb_text_banner_gen.sv
// Bench for text_banner_gen: four parameter variants share one stimulus stream
// and are compared against a geometry/ASCII-art reference model.
module tb_text_banner_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       video_on = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic [8:0] char_codes = '0;
    logic       switchR = 1'b1;
    logic       switchG = 1'b1;
    logic       switchB = 1'b1;
    logic       blink_en = 1'b0;
    logic       scroll_en = 1'b0;
    logic [2:0] rgb0, rgb1, rgb2, rgb3;

    localparam logic [8:0] CODES_RKI = {3'd3, 3'd2, 3'd1};

    always #5 clk = ~clk;

    text_banner_gen u0 (
        .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .char_codes(char_codes), .switchR(switchR), .switchG(switchG), .switchB(switchB),
        .blink_en(blink_en), .scroll_en(scroll_en), .graph_rgb(rgb0));
    text_banner_gen #(.SCALE_LOG2(1)) u1 (
        .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .char_codes(char_codes), .switchR(switchR), .switchG(switchG), .switchB(switchB),
        .blink_en(blink_en), .scroll_en(scroll_en), .graph_rgb(rgb1));
    text_banner_gen #(.X0(630)) u2 (
        .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .char_codes(char_codes), .switchR(switchR), .switchG(switchG), .switchB(switchB),
        .blink_en(blink_en), .scroll_en(scroll_en), .graph_rgb(rgb2));
    text_banner_gen #(.BLINK_FRAMES(2)) u3 (
        .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .char_codes(char_codes), .switchR(switchR), .switchG(switchG), .switchB(switchB),
        .blink_en(blink_en), .scroll_en(scroll_en), .graph_rgb(rgb3));

    int          errors = 0;
    int          checks = 0;
    logic [11:0] exp_q[$];
    logic [19:0] pix_q[$];

    int          m_off;
    int          m_cnt[4];
    bit          m_phase[4];
    logic [2:0]  m_colour;
    bit          m_prev_tick;
    string       font_art[8];

    function automatic int px0(int i); return (i == 2) ? 630 : 296; endfunction
    function automatic int ps(int i);  return (i == 1) ? 1 : 0;     endfunction
    function automatic int pbf(int i); return (i == 3) ? 2 : 30;    endfunction

    function automatic logic [2:0] rgb_of(int i);
        case (i)
            0:       return rgb0;
            1:       return rgb1;
            2:       return rgb2;
            default: return rgb3;
        endcase
    endfunction

    function automatic logic [2:0] model_pixel(int i, int x, int y, bit v);
        int s, xo, w, h, dx, dy, slot, col, row, code;
        bit vis;
        s  = ps(i);
        xo = (px0(i) + m_off) % 640;
        w  = 24 << s;
        h  = 8 << s;
        if (!v || x > 639 || x < xo || x >= xo + w || y < 240 || y >= 240 + h) return 3'b000;
        dx   = x - xo;
        dy   = y - 240;
        slot = dx / (8 << s);
        col  = (dx >> s) % 8;
        row  = (dy >> s) % 8;
        code = int'((char_codes >> (3 * slot)) & 9'h7);
        vis  = blink_en ? m_phase[i] : 1'b1;
        if (!vis || font_art[code].getc(row * 8 + col) != "#") return 3'b000;
        return m_colour;
    endfunction

    task automatic model_reset();
        m_off = 0;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]   = 0;
            m_phase[i] = 1'b1;
        end
        m_colour    = 3'b111;
        m_prev_tick = 1'b0;
        exp_q.delete();
        pix_q.delete();
    endtask

    task automatic model_tick();
        m_colour = {switchR, switchG, switchB};
        if (blink_en) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = (m_cnt[i] + 1) % pbf(i);
                if (m_cnt[i] == 0) m_phase[i] = !m_phase[i];
            end
        end
        if (scroll_en) m_off = (m_off + 1) % 640;
    endtask

    task automatic check(string tag, logic [2:0] obs, logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One pixel per clk; the output after this edge belongs to the previous pixel.
    task automatic drive_cycle(int x, int y, bit v);
        bit          is_tick;
        logic [11:0] e;
        logic [19:0] p;
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        video_on = v;
        exp_q.push_back({model_pixel(3, x, y, v), model_pixel(2, x, y, v),
                         model_pixel(1, x, y, v), model_pixel(0, x, y, v)});
        pix_q.push_back({10'(x), 10'(y)});
        is_tick     = (x == 0 && y == 480) && !m_prev_tick;
        m_prev_tick = (x == 0 && y == 480);
        @(posedge clk);
        #1;
        if (is_tick) model_tick();
        if (!blink_en) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i]   = 0;
                m_phase[i] = 1'b1;
            end
        end
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            p = pix_q.pop_front();
            for (int i = 0; i < 4; i++)
                check($sformatf("pix_u%0d_(%0d,%0d)", i, p[19:10], p[9:0]), rgb_of(i), e[3*i +: 3]);
        end
    endtask

    task automatic frame_tick_pulse();
        repeat (3) drive_cycle(0, 480, 1'b0);
        drive_cycle(1, 480, 1'b0);
    endtask

    task automatic expect_const(int i, int x, int y, logic [2:0] exp, string tag);
        drive_cycle(x, y, 1'b1);
        drive_cycle(639, 0, 1'b0);
        check($sformatf("%s_u%0d_(%0d,%0d)", tag, i, x, y), rgb_of(i), exp);
    endtask

    task automatic rand_stream(int n);
        int x, y, region;
        for (int k = 0; k < n; k++) begin
            region = $urandom_range(0, 2);
            if (region == 0)      x = $urandom_range(280, 360);
            else if (region == 1) x = $urandom_range(600, 639);
            else                  x = $urandom_range(0, 40);
            y = $urandom_range(234, 262);
            if ($urandom_range(0, 9) == 0) char_codes = 9'($urandom);
            drive_cycle(x, y, $urandom_range(0, 7) != 0);
        end
        char_codes = CODES_RKI;
    endtask

    initial begin
        font_art[0] = {8{"........"}};
        font_art[1] = {"..####..", "...##...", "...##...", "...##...",
                       "...##...", "...##...", "...##...", "..####.."};
        font_art[2] = {"##...##.", "##..##..", "##.##...", "####....",
                       "##.##...", "##..##..", "##...##.", "........"};
        font_art[3] = {"######..", "##...##.", "##...##.", "######..",
                       "##.##...", "##..##..", "##...##.", "........"};
        font_art[4] = {"..###...", ".##.##..", "##...##.", "##...##.",
                       "#######.", "##...##.", "##...##.", "........"};
        font_art[5] = {".#####..", "##...##.", "##......", ".#####..",
                       ".....##.", "##...##.", ".#####..", "........"};
        font_art[6] = {"##...##.", "###.###.", "#######.", "##.#.##.",
                       "##...##.", "##...##.", "##...##.", "........"};
        font_art[7] = {".#####..", "##...##.", "##......", "##......",
                       "##......", "##...##.", ".#####..", "........"};
        model_reset();

        // Reset state, both immediately and after clocks.
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("reset_async_u%0d", i), rgb_of(i), 3'b000);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("reset_held_u%0d", i), rgb_of(i), 3'b000);
        reset = 1'b0;

        // Default banner {R,K,I}, colour 100 loaded at a frame tick.
        char_codes = CODES_RKI;
        {switchR, switchG, switchB} = 3'b100;
        frame_tick_pulse();
        expect_const(0, 296, 240, 3'b000, "i_col0");
        expect_const(0, 298, 240, 3'b100, "i_col2");
        expect_const(0, 301, 240, 3'b100, "i_col5");
        expect_const(0, 302, 240, 3'b000, "i_col6");
        expect_const(0, 304, 240, 3'b100, "k_col0");
        expect_const(0, 309, 240, 3'b100, "k_col5");
        expect_const(0, 311, 240, 3'b000, "k_col7");
        expect_const(0, 312, 240, 3'b100, "r_col0");
        rand_stream(150);

        // Colour holds mid-frame, loads at the tick.
        {switchR, switchG, switchB} = 3'b011;
        expect_const(0, 298, 240, 3'b100, "colour_hold");
        rand_stream(30);
        frame_tick_pulse();
        expect_const(0, 298, 240, 3'b011, "colour_load");

        // Asynchronous reset while lit.
        drive_cycle(300, 242, 1'b1);
        drive_cycle(300, 242, 1'b1);
        check("lit_before_reset", rgb0, 3'b011);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("reset_mid_u%0d", i), rgb_of(i), 3'b000);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        expect_const(0, 300, 242, 3'b111, "post_reset_colour");

        // Magnified and right-edge-clipped variants.
        expect_const(1, 298, 240, 3'b000, "s1_col1_a");
        expect_const(1, 299, 241, 3'b000, "s1_col1_b");
        expect_const(1, 300, 240, 3'b111, "s1_col2");
        expect_const(1, 328, 240, 3'b111, "s1_slot2");
        expect_const(1, 341, 243, 3'b111, "s1_right");
        expect_const(1, 300, 255, 3'b111, "s1_bottom");
        expect_const(1, 300, 256, 3'b000, "s1_below");
        expect_const(2, 630, 240, 3'b000, "clip_x630");
        expect_const(2, 632, 240, 3'b111, "clip_x632");
        expect_const(2, 639, 240, 3'b111, "clip_x639");
        expect_const(2, 3, 240, 3'b000, "clip_x3");
        expect_const(2, 4, 240, 3'b000, "clip_x4");
        expect_const(2, 6, 240, 3'b000, "clip_x6");
        rand_stream(100);

        // Scrolling through a full wrap of the offset.
        {switchR, switchG, switchB} = 3'b111;
        scroll_en = 1'b1;
        repeat (344) frame_tick_pulse();
        expect_const(0, 2, 240, 3'b111, "scroll_org0");
        expect_const(0, 297, 240, 3'b000, "scroll_org0_old");
        frame_tick_pulse();
        expect_const(0, 3, 240, 3'b111, "scroll_org1");
        expect_const(0, 2, 240, 3'b000, "scroll_org1_col1");
        rand_stream(60);
        repeat (294) frame_tick_pulse();
        expect_const(0, 297, 240, 3'b111, "scroll_off639");
        frame_tick_pulse();
        expect_const(0, 298, 240, 3'b111, "scroll_wrap");
        expect_const(0, 297, 240, 3'b000, "scroll_wrap_col1");
        scroll_en = 1'b0;

        // Blink with a two-frame half period.
        blink_en = 1'b1;
        for (int f = 0; f < 7; f++) begin
            expect_const(3, 298, 240, ((f / 2) % 2 == 0) ? 3'b111 : 3'b000,
                         $sformatf("blink_f%0d", f));
            frame_tick_pulse();
        end
        blink_en = 1'b0;
        expect_const(3, 298, 240, 3'b111, "blink_clear");

        // Randomised bursts mixing every control.
        for (int b = 0; b < 8; b++) begin
            drive_cycle(639, 0, 1'b0);
            drive_cycle(639, 0, 1'b0);
            blink_en  = $urandom_range(0, 1) == 1;
            scroll_en = $urandom_range(0, 1) == 1;
            {switchR, switchG, switchB} = 3'($urandom);
            rand_stream(50);
            frame_tick_pulse();
        end
        drive_cycle(639, 0, 1'b0);
        drive_cycle(639, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
